uart_param: RTL

UART_PARAM -- requirements
Module: uart_param

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_baud_cnt.sv | 34 +++
 rtl/uart_param.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the parameterised UART.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // 115200 baud from a 50 MHz clock
  localparam int DEFAULT_CLK_DIV = 434;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PAR,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  // Parity bit that goes with data whose XOR-reduction is data_xor.
  function automatic logic par_bit(input logic data_xor, input int mode);
    return (mode == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: wraps every CLK_DIV cycles while running, with a
// full-period tick and a mid-period half tick used for start-bit sampling.
module uart_baud_cnt import uart_pkg::*; #(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic nRst,
  input  logic run,
  input  logic restart,
  output logic tick,
  output logic half_tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);

  logic [CW-1:0] cnt;

  // Count while running; held at zero when idle or restarted so a new bit period starts cleanly.
  always_ff @(posedge clk) begin
    if (!nRst || restart || !run) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick      = run && (cnt == LAST);
  assign half_tick = run && (cnt == HALF);

endmodule

// File: rtl/uart_param.sv
// Parameterised UART: independent transmitter and receiver sharing only the clock and reset.
module uart_param import uart_pkg::*; #(
  parameter int CLK_DIV   = DEFAULT_CLK_DIV,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = PAR_NONE,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 nRst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  input  logic                 rx,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  // ---------------- transmitter ----------------
  tx_state_t            tx_state;
  logic [DATA_BITS-1:0] tx_shift;
  logic                 tx_par;
  logic [3:0]           tx_bit_cnt;
  logic                 tx_stop_cnt;
  logic                 tx_tick;
  logic                 tx_half_unused;
  logic                 tx_accept;

  assign tx_accept = tx_valid && tx_ready;

  uart_baud_cnt #(.CLK_DIV(CLK_DIV)) u_tx_baud (
    .clk      (clk),
    .nRst     (nRst),
    .run      (tx_state != TX_IDLE),
    .restart  (tx_accept),
    .tick     (tx_tick),
    .half_tick(tx_half_unused)
  );

  // TX frame sequencer; tx and tx_ready are registered so the line never glitches.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      tx_state    <= TX_IDLE;
      tx          <= 1'b1;
      tx_ready    <= 1'b1;
      tx_shift    <= '0;
      tx_par      <= 1'b0;
      tx_bit_cnt  <= '0;
      tx_stop_cnt <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_accept) begin
            tx_shift <= tx_data;
            tx_par   <= par_bit(^tx_data, PARITY);
            tx       <= 1'b0;
            tx_ready <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_tick) begin
            tx         <= tx_shift[0];
            tx_shift   <= tx_shift >> 1;
            tx_bit_cnt <= '0;
            tx_state   <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            if (tx_bit_cnt == LAST_BIT) begin
              tx_stop_cnt <= 1'b0;
              if (PARITY != PAR_NONE) begin
                tx       <= tx_par;
                tx_state <= TX_PAR;
              end else begin
                tx       <= 1'b1;
                tx_state <= TX_STOP;
              end
            end else begin
              tx         <= tx_shift[0];
              tx_shift   <= tx_shift >> 1;
              tx_bit_cnt <= tx_bit_cnt + 4'd1;
            end
          end
        end
        TX_PAR: begin
          if (tx_tick) begin
            tx       <= 1'b1;
            tx_state <= TX_STOP;
          end
        end
        TX_STOP: begin
          if (tx_tick) begin
            if (tx_stop_cnt == LAST_STOP) begin
              tx_ready <= 1'b1;
              tx_state <= TX_IDLE;
            end else begin
              tx_stop_cnt <= tx_stop_cnt + 1'b1;
            end
          end
        end
        default: begin
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          tx_state <= TX_IDLE;
        end
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic [1:0]           rx_sync;
  logic                 rx_s;
  rx_state_t            rx_state;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 rx_par_s;
  logic [3:0]           rx_bit_cnt;
  logic                 rx_tick;
  logic                 rx_half;
  logic                 rx_run;

  assign rx_s   = rx_sync[1];
  assign rx_run = (rx_state == RX_START) || (rx_state == RX_DATA) ||
                  (rx_state == RX_PAR)   || (rx_state == RX_STOP);

  // Two-flop synchroniser for the asynchronous line; resets to the idle (high) level.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      rx_sync <= 2'b11;
    end else begin
      rx_sync <= {rx_sync[0], rx};
    end
  end

  uart_baud_cnt #(.CLK_DIV(CLK_DIV)) u_rx_baud (
    .clk      (clk),
    .nRst     (nRst),
    .run      (rx_run),
    .restart  ((rx_state == RX_START) && rx_half),
    .tick     (rx_tick),
    .half_tick(rx_half)
  );

  // RX frame sequencer; sampling restarts at mid start bit so every later sample lands mid-bit.
  always_ff @(posedge clk) begin
    if (!nRst) begin
      rx_state   <= RX_IDLE;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_shift   <= '0;
      rx_par_s   <= 1'b0;
      rx_bit_cnt <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_s) begin
            rx_bit_cnt <= '0;
            rx_state   <= RX_START;
          end
        end
        RX_START: begin
          if (rx_half) begin
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
            if (rx_bit_cnt == LAST_BIT) begin
              rx_state <= (PARITY != PAR_NONE) ? RX_PAR : RX_STOP;
            end else begin
              rx_bit_cnt <= rx_bit_cnt + 4'd1;
            end
          end
        end
        RX_PAR: begin
          if (rx_tick) begin
            rx_par_s <= rx_s;
            rx_state <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_tick) begin
            rx_valid   <= 1'b1;
            rx_data    <= rx_shift;
            parity_err <= (PARITY != PAR_NONE) && (rx_par_s != par_bit(^rx_shift, PARITY));
            frame_err  <= !rx_s;
            rx_state   <= rx_s ? RX_IDLE : RX_BREAK;
          end
        end
        RX_BREAK: begin
          if (rx_s) begin
            rx_state <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule
